idex_pipe_reg: RTL



---
 rtl/idex_pipe_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/idex_pipe_reg.sv
// Elastic ID/EX pipeline register: valid/ready on both sides, 2-entry skid, sync flush.
// Optional IDEX_ZERO_BUBBLE_EN: main payload is zeroed whenever EX_Valid goes low.
module idex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 10
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              ID_Valid,
  output logic              ID_Ready,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_immExt,
  input  logic [DATA_W-1:0] ID_sa,
  input  logic [REG_W-1:0]  ID_rt,
  input  logic [REG_W-1:0]  ID_rd,
  output logic              EX_Valid,
  input  logic              EX_Ready,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_immExt,
  output logic [DATA_W-1:0] EX_sa,
  output logic [REG_W-1:0]  EX_rt,
  output logic [REG_W-1:0]  EX_rd
);

  localparam int PAY_W = CTRL_W + 4*DATA_W + 2*REG_W;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             valid_q, ready_q;
  logic [PAY_W-1:0] id_pay;
  logic             in_xfer, out_xfer;

  assign id_pay   = {ID_Ctrl, ID_ReadData1, ID_ReadData2, ID_immExt, ID_sa, ID_rt, ID_rd};
  assign in_xfer  = ID_Valid & ready_q;
  assign out_xfer = valid_q & EX_Ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d = S_ONE;
          main_d  = id_pay;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = id_pay;
        end else if (in_xfer) begin
          state_d = S_FULL;
          skid_d  = id_pay;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_xfer) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush discards any same-cycle capture; the held main value is kept.
    if (Flush) begin
      state_d = S_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
`ifdef IDEX_ZERO_BUBBLE_EN
    if (state_d == S_EMPTY) begin
      main_d = '0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != S_EMPTY);
      ready_q <= (state_d != S_FULL);
    end
  end

  assign EX_Valid = valid_q;
  assign ID_Ready = ready_q;
  assign {EX_Ctrl, EX_ReadData1, EX_ReadData2, EX_immExt, EX_sa, EX_rt, EX_rd} = main_q;

endmodule
